// File: rtl/dsp48a1_mac_sequencer_if.sv
// Operand, slice and result signals of the DSP48A1 MAC sequencer.
// slave is the sequencer side; master is the surrounding environment.
interface dsp48a1_mac_sequencer_if;
  logic               start;
  logic [7:0]         len;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic [47:0]        dsp_p;
  logic               res_valid;
  logic               res_ready;
  logic [47:0]        res_data;
  logic               busy;

  modport slave (
    input  start, len, in_valid, in_a, in_b,
    input  dsp_p, res_ready,
    output in_ready, dsp_a, dsp_b, dsp_opmode,
    output dsp_ce, res_valid, res_data, busy
  );

  modport master (
    output start, len, in_valid, in_a, in_b,
    output dsp_p, res_ready,
    input  in_ready, dsp_a, dsp_b, dsp_opmode,
    input  dsp_ce, res_valid, res_data, busy
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Job controller streaming operand pairs into one DSP48A1 slice
// as a signed MAC, then draining and holding the 48-bit result.
module dsp48a1_mac_sequencer #(
  parameter int RESULT_LAT  = 3,
  parameter int OPMODE_SKEW = RESULT_LAT - 2
) (
  input logic clk,
  input logic rst,
  dsp48a1_mac_sequencer_if.slave bus
);

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] DRN_LAST  = 8'(RESULT_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  drn_q, drn_d;
  logic [47:0] res_q, res_d;
  logic [OPMODE_SKEW-1:0][7:0] opm_q;

  logic               ce;
  logic               rdy;
  logic [7:0]         opm_in;
  logic signed [17:0] a_out;
  logic signed [17:0] b_out;
  logic [7:0]         cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      res_q   <= res_d;
    end
  end

  // OPMODE words track their operands only across enabled slice edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opm_q <= {OPMODE_SKEW{OPM_ACC}};
    end else if (ce) begin
      opm_q[0] <= opm_in;
      for (int i = 1; i < OPMODE_SKEW; i++)
        opm_q[i] <= opm_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    res_d   = res_q;
    ce      = 1'b0;
    rdy     = 1'b0;
    opm_in  = OPM_ACC;
    a_out   = '0;
    b_out   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != 8'd0) begin
            state_d = S_RUN;
            len_d   = bus.len;
            cnt_d   = '0;
          end else begin
            state_d = S_HOLD;
            res_d   = '0;
          end
        end
      end
      S_RUN: begin
        rdy    = 1'b1;
        ce     = bus.in_valid;
        a_out  = bus.in_a;
        b_out  = bus.in_b;
        opm_in = (cnt_q == 8'd0) ? OPM_FIRST : OPM_ACC;
        if (bus.in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        ce = 1'b1;
        if (drn_q == DRN_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          drn_d = drn_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        res_d   = bus.dsp_p;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = rdy;
  assign bus.dsp_ce     = ce;
  assign bus.dsp_a      = a_out;
  assign bus.dsp_b      = b_out;
  assign bus.dsp_opmode = opm_q[OPMODE_SKEW-1];
  assign bus.res_valid  = (state_q == S_HOLD);
  assign bus.res_data   = res_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer driving a behavioural DSP48A1
// slice; results are checked against a plain sum of products.
module tb_dsp48a1_mac_sequencer;

  localparam int RESULT_LAT = 3;

  logic clk;
  logic rst;

  dsp48a1_mac_sequencer_if bus ();

  dsp48a1_mac_sequencer #(
    .RESULT_LAT (RESULT_LAT),
    .OPMODE_SKEW(RESULT_LAT - 2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice: A1/B1, M, OPMODE and P registers on one CE
  logic signed [17:0] s_a1 = '0;
  logic signed [17:0] s_b1 = '0;
  logic signed [35:0] s_m  = '0;
  logic [7:0]         s_op = 8'h09;
  logic [47:0]        s_p  = '0;
  logic [47:0]        s_x;
  logic [47:0]        s_z;

  assign s_x = (s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
  assign s_z = (s_op[3:2] == 2'b10) ? s_p : 48'd0;

  always_ff @(posedge clk) begin
    if (bus.dsp_ce) begin
      s_a1 <= bus.dsp_a;
      s_b1 <= bus.dsp_b;
      s_m  <= s_a1 * s_b1;
      s_op <= bus.dsp_opmode;
      s_p  <= s_z + s_x;
    end
  end

  assign bus.dsp_p = s_p;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic signed [17:0] ja [256];
  logic signed [17:0] jb [256];
  int                 jg [256];

  // Runs one job from IDLE to HOLD; result is left held
  task automatic run_job(input int n, output logic [47:0] got);
    logic signed [47:0] acc;
    int lat;
    acc = '0;
    for (int i = 0; i < n; i++) acc = acc + ja[i] * jb[i];
    chk("idle_busy", 48'(bus.busy), 48'd0);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    #1;
    chk("idle_ce", 48'(bus.dsp_ce), 48'd0);
    chk("idle_rdy", 48'(bus.in_ready), 48'd0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < jg[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in_a     = 18'($urandom);
        bus.in_b     = 18'($urandom);
        #1;
        chk("stall_rdy", 48'(bus.in_ready), 48'd1);
        chk("stall_ce", 48'(bus.dsp_ce), 48'd0);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_a     = ja[i];
      bus.in_b     = jb[i];
      #1;
      chk("acc_rdy", 48'(bus.in_ready), 48'd1);
      chk("acc_ce", 48'(bus.dsp_ce), 48'd1);
      chk("acc_dsp_a", 48'(bus.dsp_a), 48'(ja[i]));
      tick();
      chk("opmode", 48'(bus.dsp_opmode), (i == 0) ? 48'h01 : 48'h09);
    end
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 12) begin
      chk("drain_rdy", 48'(bus.in_ready), 48'd0);
      tick();
      lat++;
    end
    chk("res_lat", 48'(lat), 48'(RESULT_LAT));
    got = bus.res_data;
    chk("res_data", got, acc);
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("rel_valid", 48'(bus.res_valid), 48'd0);
    chk("rel_busy", 48'(bus.busy), 48'd0);
  endtask

  typedef struct {
    int                 n;
    int                 gap1;
    logic signed [17:0] a [4];
    logic signed [17:0] b [4];
    logic [47:0]        expv;
  } vec_t;

  function automatic vec_t mk(input int n, input int gap1,
      input int a0, input int b0, input int a1, input int b1,
      input int a2, input int b2, input int a3, input int b3,
      input logic [47:0] expv);
    vec_t v;
    v.n = n;
    v.gap1 = gap1;
    v.a[0] = 18'(a0); v.b[0] = 18'(b0);
    v.a[1] = 18'(a1); v.b[1] = 18'(b1);
    v.a[2] = 18'(a2); v.b[2] = 18'(b2);
    v.a[3] = 18'(a3); v.b[3] = 18'(b3);
    v.expv = expv;
    return v;
  endfunction

  vec_t        vecs [5];
  logic [47:0] got;
  logic [47:0] held;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(3, 0, 2, 3, 4, 5, -1, 7, 0, 0, 48'd19);
    vecs[1] = mk(3, 2, 2, 3, 4, 5, -1, 7, 0, 0, 48'd19);
    vecs[2] = mk(2, 0, -131072, -131072, -131072, -131072,
                 0, 0, 0, 0, 48'h0008_0000_0000);
    vecs[3] = mk(1, 0, 3, 3, 0, 0, 0, 0, 0, 0, 48'd9);
    vecs[4] = mk(4, 1, 100, -200, -5, -6, 131071, 131071,
                 -131072, 131071, -48'sd151041);

    rst = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    #2;
    chk("rst_rdy", 48'(bus.in_ready), 48'd0);
    chk("rst_ce", 48'(bus.dsp_ce), 48'd0);
    chk("rst_valid", 48'(bus.res_valid), 48'd0);
    chk("rst_busy", 48'(bus.busy), 48'd0);
    chk("rst_opmode", 48'(bus.dsp_opmode), 48'h09);
    chk("rst_data", bus.res_data, 48'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        ja[i] = vecs[v].a[i];
        jb[i] = vecs[v].b[i];
        jg[i] = (i == 1) ? vecs[v].gap1 : 0;
      end
      run_job(vecs[v].n, got);
      chk("vec_res", got, vecs[v].expv);
      release_res();
    end

    // len = 0: immediate zero result, slice untouched
    bus.start = 1'b1;
    bus.len   = 8'd0;
    #1;
    chk("len0_ce0", 48'(bus.dsp_ce), 48'd0);
    tick();
    bus.start = 1'b0;
    chk("len0_valid", 48'(bus.res_valid), 48'd1);
    chk("len0_data", bus.res_data, 48'd0);
    chk("len0_ce1", 48'(bus.dsp_ce), 48'd0);
    release_res();

    // Held result survives start pulses while res_ready is low
    ja[0] = 18'sd1000; jb[0] = -18'sd77; jg[0] = 0;
    ja[1] = -18'sd12;  jb[1] = 18'sd12;  jg[1] = 0;
    run_job(2, held);
    for (int k = 0; k < 5; k++) begin
      bus.start = ((k % 2) == 0);
      bus.len   = 8'd1;
      #1;
      chk("hold_valid", 48'(bus.res_valid), 48'd1);
      chk("hold_ce", 48'(bus.dsp_ce), 48'd0);
      chk("hold_rdy", 48'(bus.in_ready), 48'd0);
      tick();
      chk("hold_data", bus.res_data, held);
    end
    bus.start = 1'b0;
    release_res();
    ja[0] = 18'sd3; jb[0] = 18'sd3; jg[0] = 0;
    run_job(1, got);
    chk("after_hold", got, 48'd9);
    release_res();

    // Reset in the middle of a 4-pair job
    bus.start = 1'b1;
    bus.len   = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 18'sd1234 + 18'(i);
      bus.in_b     = -18'sd999;
      tick();
    end
    bus.in_a = 18'sd77;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 48'(bus.in_ready), 48'd0);
    chk("mid_rst_ce", 48'(bus.dsp_ce), 48'd0);
    chk("mid_rst_valid", 48'(bus.res_valid), 48'd0);
    chk("mid_rst_busy", 48'(bus.busy), 48'd0);
    chk("mid_rst_a", 48'(bus.dsp_a), 48'd0);
    chk("mid_rst_opm", 48'(bus.dsp_opmode), 48'h09);
    chk("mid_rst_data", bus.res_data, 48'd0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    ja[0] = 18'sd5; jb[0] = -18'sd4; jg[0] = 0;
    run_job(1, got);
    chk("after_rst", got, 48'hFFFF_FFFF_FFEC);
    release_res();

    // Randomized jobs, including one maximum-length job
    for (int j = 0; j < 25; j++) begin
      int n;
      n = (j == 12) ? 255 : int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) begin
        ja[i] = 18'($urandom);
        jb[i] = 18'($urandom);
        jg[i] = ($urandom_range(0, 1) == 0) ? 0
                : int'($urandom_range(1, 3));
        if (j == 12) jg[i] = 0;
      end
      run_job(n, got);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        tick();
        chk("rnd_hold", bus.res_data, got);
      end
      release_res();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
